// File: rtl/m_sequence_gen_prog.sv
// Programmable M-sequence chip generator: run-time phase seek, chip hold,
// repetition count, continuous mode and abort.
module m_sequence_gen_prog #(
  parameter int unsigned       WIDTH  = 6,
  parameter logic [WIDTH-1:0]  POLY   = 6'b000011,
  parameter logic [WIDTH-1:0]  SEED   = 6'b101010,
  parameter int unsigned       HOLD_W = 4,
  parameter int unsigned       REP_W  = 8
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              start_i,
  output logic              ready_o,
  input  logic [WIDTH-1:0]  shift_i,
  input  logic [HOLD_W-1:0] hold_i,
  input  logic [REP_W-1:0]  reps_i,
  input  logic              abort_i,
  output logic              out_o,
  output logic              strobe_o,
  output logic              period_o,
  output logic              done_o
);

  if (SEED == '0) begin : g_seed_chk
    $error("m_sequence_gen_prog: SEED must be nonzero");
  end

  localparam logic [WIDTH-1:0]  N        = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]  LAST     = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0]  SEEK_ONE = WIDTH'(1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [REP_W-1:0]  REP_ONE  = REP_W'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEEK = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  lfsr_q, lfsr_d;
  logic [WIDTH-1:0]  seek_q, seek_d;
  logic [WIDTH-1:0]  chip_q, chip_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] hcnt_q, hcnt_d;
  logic [REP_W-1:0]  rem_q, rem_d;
  logic              done_q, done_d;

  logic [WIDTH-1:0]  lfsr_step;
  logic [WIDTH-1:0]  shift_eff;
  logic [HOLD_W-1:0] hold_eff;
  logic              run;

  assign lfsr_step = {^(POLY & lfsr_q), lfsr_q[WIDTH-1:1]};
  assign shift_eff = (shift_i == N) ? '0 : shift_i;
  assign hold_eff  = (hold_i == '0) ? HOLD_ONE : hold_i;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    seek_d  = seek_q;
    chip_d  = chip_q;
    hold_d  = hold_q;
    hcnt_d  = hcnt_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          lfsr_d  = SEED;
          seek_d  = shift_eff;
          hold_d  = hold_eff;
          hcnt_d  = hold_eff - HOLD_ONE;
          chip_d  = '0;
          rem_d   = reps_i;
          state_d = (shift_eff != '0) ? S_SEEK : S_RUN;
        end
      end
      S_SEEK: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          lfsr_d = lfsr_step;
          seek_d = seek_q - SEEK_ONE;
          if (seek_q == SEEK_ONE) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (hcnt_q == '0) begin
          // last cycle of a chip: advance to the next one
          lfsr_d = lfsr_step;
          hcnt_d = hold_q - HOLD_ONE;
          if (chip_q == LAST) begin
            chip_d = '0;
            if (rem_q == REP_ONE) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else if (rem_q != '0) begin
              rem_d = rem_q - REP_ONE;
            end
          end else begin
            chip_d = chip_q + SEEK_ONE;
          end
        end else begin
          hcnt_d = hcnt_q - HOLD_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      seek_q  <= '0;
      chip_q  <= '0;
      hold_q  <= '0;
      hcnt_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      seek_q  <= seek_d;
      chip_q  <= chip_d;
      hold_q  <= hold_d;
      hcnt_q  <= hcnt_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  assign run      = (state_q == S_RUN);
  assign ready_o  = (state_q == S_IDLE);
  assign out_o    = run & lfsr_q[0];
  assign strobe_o = run && (hcnt_q == hold_q - HOLD_ONE);
  assign period_o = strobe_o && (chip_q == '0);
  assign done_o   = done_q;

endmodule

// File: tb/tb_m_sequence_gen_prog.sv
// Randomised scoreboard bench for m_sequence_gen_prog: driver pushes
// expected chips/done pulses, monitor pops them as the DUT presents them.
module tb_m_sequence_gen_prog;

  localparam int W    = 6;
  localparam int N    = 63;
  localparam int POLY = 6'b000011;
  localparam int SEED = 6'b101010;

  typedef struct {
    int cyc;
    bit chip;
    bit per;
    int hold;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic       abort_i = 1'b0;
  logic [5:0] shift_i = '0;
  logic [3:0] hold_i = '0;
  logic [7:0] reps_i = '0;
  logic       ready_o, out_o, strobe_o, period_o, done_o;

  m_sequence_gen_prog dut (
    .clkin   (clk),
    .rst     (rst),
    .start_i (start_i),
    .ready_o (ready_o),
    .shift_i (shift_i),
    .hold_i  (hold_i),
    .reps_i  (reps_i),
    .abort_i (abort_i),
    .out_o   (out_o),
    .strobe_o(strobe_o),
    .period_o(period_o),
    .done_o  (done_o)
  );

  always #5 clk = ~clk;

  int     cyc = 0;
  int     tests = 0;
  int     fails = 0;
  bit     seq [N];
  rec_t   q[$];
  int     dq[$];
  longint idle_from = 0;
  int     kill_cyc = 0;
  bit     mon_on = 0;
  int     cur_start = 0;
  int     cur_end = 0;
  bit     cur_chip = 0;
  rec_t   mrec;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
    end
  endtask

  // reference chip table: one period of the sequence starting at phase 0
  function automatic void build_seq();
    int st = SEED;
    for (int k = 0; k < N; k++) begin
      int fb;
      seq[k] = bit'(st & 1);
      fb = $countones(st & POLY) & 1;
      st = (st >> 1) | (fb << (W - 1));
    end
  endfunction

  function automatic void purge(input int c);
    while (q.size() > 0 && q[$].cyc > c) void'(q.pop_back());
    while (dq.size() > 0 && dq[$] > c) void'(dq.pop_back());
  endfunction

  function automatic void accept(input int c, input int s, input int h,
                                 input int r, input int lim_rel);
    int s_eff = (s == N) ? 0 : s;
    int hh    = (h == 0) ? 1 : h;
    int first = c + 1 + s_eff;
    int limit = (lim_rel > 0) ? c + lim_rel : c + 4000;
    int nch   = (r == 0) ? 1 << 30 : N * r;
    for (int k = 0; k < nch; k++) begin
      rec_t e;
      e.cyc = first + k * hh;
      if (r == 0 && e.cyc > limit) break;
      e.chip = seq[(s_eff + k) % N];
      e.per  = ((k % N) == 0);
      e.hold = hh;
      q.push_back(e);
    end
    if (r > 0) begin
      idle_from = longint'(first + N * hh * r);
      dq.push_back(first + N * hh * r);
    end else begin
      idle_from = 64'd1 << 40;
    end
  endfunction

  task automatic tick(input bit st, input bit ab, input logic [5:0] sh,
                      input logic [3:0] h, input logic [7:0] r,
                      input int lim_rel);
    int c;
    @(negedge clk);
    #1;
    start_i = st;
    abort_i = ab;
    shift_i = sh;
    hold_i  = h;
    reps_i  = r;
    c = cyc;
    if (ab) begin
      if (longint'(c) < idle_from) begin
        purge(c);
        idle_from = c + 1;
        kill_cyc  = c + 1;
      end
    end else if (st && longint'(c) >= idle_from) begin
      accept(c, int'(sh), int'(h), int'(r), lim_rel);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0, '0, '0, 0);
  endtask

  // leave the next tick landing exactly on the cycle the model turns idle
  task automatic wait_ready();
    int g = 0;
    while (longint'(cyc + 1) < idle_from && g < 5000) begin
      tick(1'b0, 1'b0, '0, '0, '0, 0);
      g++;
    end
    check("wait_timeout", g < 5000, 1);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #1;
    rst = 1'b1;
    start_i = 1'b0;
    abort_i = 1'b0;
    purge(cyc);
    idle_from = cyc + 1;
    kill_cyc  = cyc + 1;
    for (int i = 1; i < n; i++) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      check("ready", ready_o, longint'(cyc) >= idle_from);
      if (strobe_o) begin
        if (q.size() == 0) begin
          check("extra_strobe", 1, 0);
        end else begin
          mrec = q.pop_front();
          check("strobe_cyc", cyc, mrec.cyc);
          check("chip", out_o, mrec.chip);
          check("period", period_o, mrec.per);
          cur_chip  = mrec.chip;
          cur_start = cyc;
          cur_end   = cyc + mrec.hold;
        end
      end else begin
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          check("missing_strobe", 0, 1);
          void'(q.pop_front());
        end
        if (cyc < cur_end && !(kill_cyc > cur_start && cyc >= kill_cyc))
          check("out_hold", out_o, cur_chip);
        else
          check("out_idle", out_o, 0);
        check("period_nostb", period_o, 0);
      end
      if (done_o) begin
        if (dq.size() == 0) check("extra_done", 1, 0);
        else check("done_cyc", cyc, dq.pop_front());
      end else if (dq.size() > 0 && dq[0] <= cyc) begin
        check("missing_done", 0, 1);
        void'(dq.pop_front());
      end
    end
  end

  initial begin
    build_seq();
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", ready_o, 1);
    check("rst_out", out_o, 0);
    check("rst_strobe", strobe_o, 0);
    check("rst_done", done_o, 0);
    #1;
    rst = 1'b0;
    idle_from = cyc;
    mon_on = 1'b1;
    idle(3);

    tick(1'b1, 1'b0, 6'd0, 4'd1, 8'd1, 0);
    wait_ready();
    idle(2);
    tick(1'b1, 1'b0, 6'd3, 4'd3, 8'd1, 0);
    wait_ready();
    idle(2);
    tick(1'b1, 1'b0, 6'd0, 4'd1, 8'd2, 0);
    wait_ready();
    idle(1);
    tick(1'b1, 1'b0, 6'd0, 4'd0, 8'd2, 0);
    wait_ready();
    idle(2);
    tick(1'b1, 1'b0, 6'd0, 4'd2, 8'd0, 200);
    idle(199);
    tick(1'b0, 1'b1, '0, '0, '0, 0);
    idle(4);

    tick(1'b1, 1'b0, 6'd5, 4'd2, 8'd1, 0);
    idle(20);
    tick(1'b1, 1'b0, 6'd9, 4'd7, 8'd3, 0);
    wait_ready();
    tick(1'b1, 1'b0, 6'd63, 4'd15, 8'd1, 0);
    wait_ready();
    tick(1'b1, 1'b0, 6'd62, 4'd1, 8'd1, 0);
    wait_ready();
    idle(1);
    tick(1'b1, 1'b1, 6'd1, 4'd1, 8'd1, 0);
    idle(5);
    tick(1'b1, 1'b0, 6'd2, 4'd4, 8'd3, 0);
    idle(50);
    do_reset(2);
    idle(5);

    for (int it = 0; it < 10; it++) begin
      logic [5:0] s = 6'($urandom_range(0, 63));
      logic [3:0] h = 4'($urandom_range(0, 15));
      logic [7:0] r = 8'($urandom_range(0, 2));
      bit do_ab = (r == 0) || ($urandom_range(0, 3) == 0);
      int d = $urandom_range(1, 300);
      tick(1'b1, 1'b0, s, h, r, do_ab ? d : 0);
      if (do_ab) begin
        for (int i = 1; i < d; i++)
          tick($urandom_range(0, 7) == 0, 1'b0,
               6'($urandom), 4'($urandom), 8'($urandom_range(1, 2)), 0);
        tick(1'b0, 1'b1, '0, '0, '0, 0);
      end
      wait_ready();
      idle($urandom_range(0, 3));
    end

    idle(5);
    check("sb_empty", q.size() + dq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
